instruction_fetch_unit: RTL

//  Fetch stage of the MIPS datapath: owns the PC, issues requests to instruction memory, and holds the IF/ID register.
//  Its Instruction output feeds the instruction decode/control stage directly.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/if_id_reg.sv | 41 ++++
 rtl/instruction_fetch_unit.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: word width, NOP, opcodes and fetch FSM states.
package mips_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic [WORD_W-1:0] NOP = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  typedef enum logic [1:0] {StFetch, StHold, StDrain} fetch_state_e;

  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush clears to a bubble, load captures a fetched word, else hold.
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] NOP_INSTR = NOP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              flush,
  input  logic [WORD_W-1:0] instr_in,
  input  logic [WORD_W-1:0] pcplus4_in,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] pcplus4,
  output logic              valid
);

  logic [WORD_W-1:0] instr_q, pcplus4_q;
  logic              valid_q;

  // PC+4 is kept across a flush; only the instruction and valid bit are cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q   <= NOP_INSTR;
      pcplus4_q <= '0;
      valid_q   <= 1'b0;
    end else if (flush) begin
      instr_q   <= NOP_INSTR;
      valid_q   <= 1'b0;
    end else if (load) begin
      instr_q   <= instr_in;
      pcplus4_q <= pcplus4_in;
      valid_q   <= 1'b1;
    end
  end

  assign instr   = instr_q;
  assign pcplus4 = pcplus4_q;
  assign valid   = valid_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS fetch stage: PC, req/valid memory handshake, skid buffer and IF/ID register.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module instruction_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [WORD_W-1:0] NOP_INSTR = NOP
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              Redirect,
  input  logic [WORD_W-1:0] RedirectPC,
  output logic              IMemReq,
  output logic [WORD_W-1:0] IMemAddr,
  input  logic [WORD_W-1:0] IMemRdata,
  input  logic              IMemValid,
  output logic [WORD_W-1:0] Instruction,
  output logic [WORD_W-1:0] PCPlus4,
  output logic              IFIDValid
`ifdef FETCH_PERF_EN
  ,
  output logic [WORD_W-1:0] FetchCount,
  output logic [WORD_W-1:0] FlushCount
`endif
);

  fetch_state_e      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] skid_q, skid_d;
  logic [WORD_W-1:0] target_q, target_d;
  logic              started_q;
  logic              load, flush;
  logic [WORD_W-1:0] load_instr;
  logic [WORD_W-1:0] pc_plus4;
  logic [WORD_W-1:0] redirect_tgt;
  logic              rsp;

  assign pc_plus4     = pc_q + 32'd4;
  assign redirect_tgt = word_align(RedirectPC);
  // A response only counts once the first request after reset has been issued.
  assign rsp          = started_q & IMemValid;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC;
      skid_q    <= '0;
      target_q  <= '0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      skid_q    <= skid_d;
      target_q  <= target_d;
      started_q <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    skid_d     = skid_q;
    target_d   = target_q;
    load       = 1'b0;
    flush      = 1'b0;
    load_instr = IMemRdata;
    unique case (state_q)
      StFetch: begin
        if (Redirect) begin
          flush = 1'b1;
          // With a request still in flight the data must be drained before retargeting.
          if (rsp || !started_q) begin
            pc_d = redirect_tgt;
          end else begin
            target_d = redirect_tgt;
            state_d  = StDrain;
          end
        end else if (rsp) begin
          if (Stall) begin
            skid_d  = IMemRdata;
            state_d = StHold;
          end else begin
            load = 1'b1;
            pc_d = pc_plus4;
          end
        end else if (!Stall) begin
          flush = 1'b1;
        end
      end
      StHold: begin
        if (Redirect) begin
          flush   = 1'b1;
          pc_d    = redirect_tgt;
          state_d = StFetch;
        end else if (!Stall) begin
          load       = 1'b1;
          load_instr = skid_q;
          pc_d       = pc_plus4;
          state_d    = StFetch;
        end
      end
      StDrain: begin
        flush = 1'b1;
        if (Redirect) begin
          target_d = redirect_tgt;
        end
        if (rsp) begin
          pc_d    = Redirect ? redirect_tgt : target_q;
          state_d = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  always_comb begin
    IMemReq  = started_q && (state_q != StHold);
    IMemAddr = pc_q;
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk        (Clk),
    .rst_n      (Reset),
    .load       (load),
    .flush      (flush),
    .instr_in   (load_instr),
    .pcplus4_in (pc_plus4),
    .instr      (Instruction),
    .pcplus4    (PCPlus4),
    .valid      (IFIDValid)
  );

`ifdef FETCH_PERF_EN
  logic [WORD_W-1:0] fetch_cnt_q, flush_cnt_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (load) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (Redirect) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign FetchCount = fetch_cnt_q;
  assign FlushCount = flush_cnt_q;
`endif

endmodule
